// File: rtl/gpu_pkg.sv
// Shared GPU types: colour, frame buffer address width and raster timing bundle.
// Scanout, frame buffer and bench all agree on these definitions.
package gpu_pkg;

  typedef logic [7:0] color_t;

  localparam int FB_ADDR_W = 17;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } scan_timing_t;

  // Control bits that travel alongside the frame buffer read latency
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic fstart;
  } scan_ctl_t;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  function automatic int scan_h_total(scan_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int scan_v_total(scan_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/scan_delay.sv
// Fixed-depth shift register with async active-low clear; re-times scanout
// control bits to match frame buffer read latency.
module scan_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 4
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stg [DEPTH];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Raster timing generator and frame buffer reader; emits one pixel per clock
// with hsync/vsync/de/frame_start aligned to the returned colour.
module fb_scanout
  import gpu_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 6,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  color_t            fb_rd_data,
  output color_t            pix_data,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam scan_timing_t TIM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };
  localparam int H_TOTAL = scan_h_total(TIM);
  localparam int V_TOTAL = scan_v_total(TIM);
  localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // One spare bit so window ends equal to 2^W still compare correctly
  localparam logic [HC_W:0] H_ACT_C  = (HC_W+1)'(H_ACTIVE);
  localparam logic [HC_W:0] HS_BEG   = (HC_W+1)'(H_ACTIVE + H_FP);
  localparam logic [HC_W:0] HS_END   = (HC_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W:0] H_LAST   = (HC_W+1)'(H_TOTAL - 1);
  localparam logic [VC_W:0] V_ACT_C  = (VC_W+1)'(V_ACTIVE);
  localparam logic [VC_W:0] VS_BEG   = (VC_W+1)'(V_ACTIVE + V_FP);
  localparam logic [VC_W:0] VS_END   = (VC_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W:0] V_LAST   = (VC_W+1)'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  scan_state_t       r_state, w_state_nxt;
  logic [HC_W-1:0]   r_h_cnt;
  logic [VC_W-1:0]   r_v_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic [HC_W:0] w_h;
  logic [VC_W:0] w_v;
  logic          w_run, w_h_last, w_v_last, w_frame_end, w_active;
  scan_ctl_t     w_raw, w_dly;

  assign w_h         = {1'b0, r_h_cnt};
  assign w_v         = {1'b0, r_v_cnt};
  assign w_run       = (r_state == SCAN_RUN);
  assign w_h_last    = (w_h == H_LAST);
  assign w_v_last    = (w_v == V_LAST);
  assign w_frame_end = w_run && w_h_last && w_v_last;
  assign w_active    = w_run && (w_h < H_ACT_C) && (w_v < V_ACT_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SCAN_IDLE;
    else        r_state <= w_state_nxt;
  end

  // enable only matters in IDLE or on the last clock of a frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN_IDLE: if (enable) w_state_nxt = SCAN_RUN;
      SCAN_RUN:  if (w_frame_end && !enable) w_state_nxt = SCAN_IDLE;
      default:   w_state_nxt = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HC_W'(1);
    end
  end

  // Raster-order address walks 0..H_ACTIVE*V_ACTIVE-1 without a multiplier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (!w_run || w_frame_end) begin
      r_addr <= '0;
    end else if (w_active) begin
      r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);
    end
  end

  assign fb_rd_en   = w_active;
  assign fb_rd_addr = r_addr;

  always_comb begin
    w_raw        = '0;
    w_raw.active = w_active;
    w_raw.hsync  = w_run && (w_h >= HS_BEG) && (w_h < HS_END);
    w_raw.vsync  = w_run && (w_v >= VS_BEG) && (w_v < VS_END);
    w_raw.fstart = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  scan_delay #(
    .DEPTH (RD_LAT),
    .WIDTH ($bits(scan_ctl_t))
  ) u_dly (
    .gclk   (clk),
    .grst_n (reset),
    .i_d    (w_raw),
    .o_q    (w_dly)
  );

  // Delayed control now lines up with the colour the read returned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_data    <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_data    <= w_dly.active ? fb_rd_data : '0;
      de          <= w_dly.active;
      hsync       <= w_dly.hsync;
      vsync       <= w_dly.vsync;
      frame_start <= w_dly.fstart;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: RD_LAT=1 and RD_LAT=3 instances on a small raster,
// closed-form expected stream scoreboarded per cycle plus spot-vector table.
module tb_fb_scanout;
  import gpu_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  logic rd_en1, rd_en3;
  logic [FB_ADDR_W-1:0] addr1, addr3;
  color_t rdata1, rdata3, pix1, pix3;
  logic de1, hs1, vs1, fs1, de3, hs3, vs3, fs3;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(FB_ADDR_W), .RD_LAT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_rd_en(rd_en1), .fb_rd_addr(addr1), .fb_rd_data(rdata1),
    .pix_data(pix1), .de(de1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(FB_ADDR_W), .RD_LAT(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_rd_en(rd_en3), .fb_rd_addr(addr3), .fb_rd_data(rdata3),
    .pix_data(pix3), .de(de3), .hsync(hs3), .vsync(vs3), .frame_start(fs3)
  );

  always #5 clk = ~clk;

  // Frame buffer models: colour = addr[7:0]; 0xEE when not read
  color_t fb1, fb3a, fb3b, fb3c;
  always @(posedge clk) begin
    fb1  <= rd_en1 ? addr1[7:0] : 8'hEE;
    fb3a <= rd_en3 ? addr3[7:0] : 8'hEE;
    fb3b <= fb3a;
    fb3c <= fb3b;
  end
  assign rdata1 = fb1;
  assign rdata3 = fb3c;

  typedef struct {
    int         due;
    logic       de, hs, vs, fs;
    logic [7:0] pix;
  } exp_t;

  typedef struct {
    int         k;
    logic       de, hs, vs, fs;
    logic [7:0] pix;
  } vec_t;

  exp_t q1[$], q3[$];
  vec_t tbl[$];
  int fs_log[$], fs3_log[$];
  logic [11:0] hist [0:199];

  int  checks = 0, errors = 0;
  int  cyc = 0, base = 0;
  int  late_rd = 0, late_out = 0;
  bit  m_run = 0;
  int  m_pos = 0;
  bit  rec_on = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs for raster position pos (pos = clocks since frame start)
  function automatic exp_t model(bit run, int pos, int due);
    exp_t e;
    int h, v;
    h = pos % HT;
    v = pos / HT;
    e.due = due;
    e.de  = run && (h < HA) && (v < VA);
    e.hs  = run && (h >= HA + HF) && (h < HA + HF + HS);
    e.vs  = run && (v >= VA + VF) && (v < VA + VF + VS);
    e.fs  = run && (pos == 0);
    e.pix = e.de ? 8'(v * HA + h) : 8'h00;
    return e;
  endfunction

  function automatic logic [11:0] pk(exp_t e);
    return {e.de, e.hs, e.vs, e.fs, e.pix};
  endfunction

  task automatic add_vec(int k, bit d, bit h, bit v, bit f, int p);
    vec_t t;
    t.k = k; t.de = d; t.hs = h; t.vs = v; t.fs = f; t.pix = 8'(p);
    tbl.push_back(t);
  endtask

  // One clock: advance reference raster, queue expectations, check stage 0 and due outputs
  task automatic tick();
    bit   en_s;
    exp_t e;
    int   k;
    en_s = enable;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      if (en_s) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == FT - 1) begin
      m_pos = 0;
      if (!en_s) m_run = 0;
    end else begin
      m_pos++;
    end
    q1.push_back(model(m_run, m_pos, cyc + 2));
    q3.push_back(model(m_run, m_pos, cyc + 4));
    #1;
    e = model(m_run, m_pos, 0);
    chk("rd_en1", rd_en1, e.de);
    chk("rd_en3", rd_en3, e.de);
    if (e.de) begin
      chk("addr1", addr1, (m_pos / HT) * HA + (m_pos % HT));
      chk("addr3", addr3, (m_pos / HT) * HA + (m_pos % HT));
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      if (e.due == cyc) chk("out1", {de1, hs1, vs1, fs1, pix1}, pk(e));
    end
    while (q3.size() > 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      if (e.due == cyc) chk("out3", {de3, hs3, vs3, fs3, pix3}, pk(e));
    end
    k = cyc - base;
    if (rec_on && k >= 0 && k < 200) hist[k] = {de1, hs1, vs1, fs1, pix1};
    if (fs1) fs_log.push_back(k);
    if (fs3) fs3_log.push_back(k);
    if (k >= 48 && rd_en1) late_rd++;
    if (k >= 50 && {de1, hs1, vs1, fs1, pix1} != 12'h000) late_out++;
  endtask

  task automatic restart();
    reset = 1'b0;
    enable = 1'b0;
    q1.delete(); q3.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    base = cyc;
    fs_log.delete(); fs3_log.delete();
    late_rd = 0; late_out = 0;
  endtask

  initial begin
    // k = clocks after the RUN-entry edge; RD_LAT=1 outputs show position k-2
    add_vec( 2, 1, 0, 0, 1, 8'h00);
    add_vec( 3, 1, 0, 0, 0, 8'h01);
    add_vec( 5, 1, 0, 0, 0, 8'h03);
    add_vec( 6, 0, 0, 0, 0, 8'h00);
    add_vec( 7, 0, 1, 0, 0, 8'h00);
    add_vec( 8, 0, 1, 0, 0, 8'h00);
    add_vec( 9, 0, 0, 0, 0, 8'h00);
    add_vec(10, 1, 0, 0, 0, 8'h04);
    add_vec(21, 1, 0, 0, 0, 8'h0B);
    add_vec(23, 0, 1, 0, 0, 8'h00);
    add_vec(26, 0, 0, 0, 0, 8'h00);
    add_vec(34, 0, 0, 1, 0, 8'h00);
    add_vec(39, 0, 1, 1, 0, 8'h00);
    add_vec(42, 0, 0, 0, 0, 8'h00);
    add_vec(50, 1, 0, 0, 1, 8'h00);
    add_vec(51, 1, 0, 0, 0, 8'h01);

    #1;
    chk("rst_out1", {de1, hs1, vs1, fs1, pix1}, 0);
    chk("rst_out3", {de3, hs3, vs3, fs3, pix3}, 0);
    chk("rst_rd_en", rd_en1, 0);
    chk("rst_addr", addr1, 0);

    // Enable from reset, then back-to-back frames
    restart();
    rec_on = 1'b1;
    repeat (150) tick();
    chk("fs_count", fs_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("fs_time", (i < fs_log.size()) ? fs_log[i] : -1, 2 + FT * i);
    chk("fs3_count", fs3_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("fs3_time", (i < fs3_log.size()) ? fs3_log[i] : -1, 4 + FT * i);
    for (int i = 0; i < tbl.size(); i++)
      chk($sformatf("vec_k%0d", tbl[i].k), hist[tbl[i].k],
          {tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].pix});

    // Stop at frame boundary: enable dropped mid-frame
    restart();
    repeat (21) tick();
    enable = 1'b0;
    repeat (130) tick();
    chk("stop_rd_en", late_rd, 0);
    chk("stop_out", late_out, 0);
    chk("stop_fs_count", fs_log.size(), 1);
    chk("stop_completes", hist[41], 12'h200);

    // Mid-frame reset clears outputs before the next edge
    restart();
    repeat (17) tick();
    #3;
    reset = 1'b0;
    #1;
    chk("mrst_out1", {de1, hs1, vs1, fs1, pix1}, 0);
    chk("mrst_out3", {de3, hs3, vs3, fs3, pix3}, 0);
    chk("mrst_rd_en", rd_en1, 0);
    chk("mrst_addr", addr1, 0);
    q1.delete(); q3.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    base = cyc;
    fs_log.delete(); fs3_log.delete();
    repeat (10) tick();
    chk("mrst_fs_count", fs_log.size(), 1);
    chk("mrst_fs_time", (fs_log.size() > 0) ? fs_log[0] : -1, 2);
    chk("mrst_fs3_time", (fs3_log.size() > 0) ? fs3_log[0] : -1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Display-side consumer of the frame buffer that the line-drawing command path writes into.
- Generates raster timing and issues sequential read requests on the frame buffer's read port.
- Re-aligns the returned 8-bit colour with hsync, vsync and data-enable to form a pixel stream for a video encoder or a bench monitor.
- Runs on the GPU clock; one pixel per clock.

Parameters:
- H_ACTIVE, 320: visible pixels per line.
- H_FP, 8: horizontal front porch, in clocks.
- H_SYNC, 32: hsync width, in clocks.
- H_BP, 40: horizontal back porch, in clocks.
- V_ACTIVE, 240: visible lines per frame.
- V_FP, 3: vertical front porch, in lines.
- V_SYNC, 4: vsync width, in lines.
- V_BP, 6: vertical back porch, in lines.
- ADDR_W, 17: frame buffer address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- RD_LAT, 1: frame buffer read latency in clocks, legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scanout enable; sampled only at a frame boundary.
- fb_rd_en  out  1  frame buffer read strobe.
- fb_rd_addr  out  ADDR_W  frame buffer read address, y*H_ACTIVE+x.
- fb_rd_data  in  8  colour returned RD_LAT clocks after fb_rd_en.
- pix_data  out  8  output colour; 0 outside the active region.
- de  out  1  data enable; high on active pixels.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- frame_start  out  1  one-clock pulse aligned with pixel (0,0).

Behaviour:
- Reset (reset=0, asynchronous):
  - h_cnt=0, v_cnt=0, addr=0, running=0.
  - All outputs 0; delay-line contents 0.
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- States:
  - IDLE: counters held at 0, fb_rd_en=0. Go to RUN when enable=1.
  - RUN: h_cnt increments every clock. On h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At the end of a frame (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1) both counters wrap to 0. Then:
    - enable=1: stay in RUN with no gap clock.
    - enable=0: go to IDLE.
- enable dropping mid-frame has no effect until the frame completes. No partial frames are ever emitted.
- Stage 0 (combinational from the counters):
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - fb_rd_en = active and RUN.
  - fb_rd_addr = addr.
- Address counter:
  - Incremental; no multiplier.
  - Increments by 1 on each active clock.
  - Reset to 0 at the frame wrap. Never exceeds H_ACTIVE*V_ACTIVE-1.
- Sync windows:
  - hsync_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync_raw = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), held for whole lines.
- frame_start_raw = RUN and h_cnt=0 and v_cnt=0.
- Alignment:
  - active, hsync_raw, vsync_raw and frame_start_raw pass through an RD_LAT-deep shift register, then one output register.
  - pix_data is registered as fb_rd_data when the delayed active is 1, else 0.
  - Total latency from a counter value to its outputs is RD_LAT+1 clocks.
- In IDLE all raw signals are 0. Outputs drain to 0 within RD_LAT+1 clocks.
- Reset asserted mid-frame clears everything immediately. After release, the block restarts from IDLE.
- Width rules:
  - Counters are sized with $clog2 of their totals.
  - addr is ADDR_W bits.
  - All comparisons are unsigned.

Decomposition:
- gpu_pkg:
  - typedef color_t (logic [7:0]).
  - Constant FB_ADDR_W.
  - A scan_timing_t struct bundling the eight timing values. Shared with the frame buffer and the bench.
- One sub-module, scan_delay: parameterised-depth, parameterised-width shift register with async active-low clear. It carries {active, hsync, vsync, frame_start}.
- The FSM and counters stay in fb_scanout.

Test Plan:
Common setup: H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), RD_LAT=1, frame buffer model returning data = addr[7:0].
- Enable from reset:
  - enable=1 one clock after reset release.
  - frame_start pulses 2 clocks after RUN entry.
  - de pattern per line is 4 high, 4 low for 3 lines, then 3 lines low.
  - pix_data sequence is 0x00..0x0B.
- Sync placement:
  - hsync is high exactly at output clocks 5-6 of each 8-clock line.
  - vsync is high for all 8 clocks of line 4.
  - Period is 48 clocks.
- Stop at boundary:
  - Drop enable at output clock 20 of frame 1.
  - The frame completes; fb_rd_en stays 0 thereafter.
  - All outputs are 0 by clock 50. No second frame_start.
- Back-to-back frames: enable held high gives frame_start exactly every 48 clocks, and addr restarts at 0 each frame.
- Latency sweep: RD_LAT=3 gives identical waveforms shifted by 2 clocks; pix_data still matches addr.
- Mid-frame reset: reset pulsed low at clock 17 clears all outputs asynchronously (before the next edge); after release with enable=1, the first frame_start is at clock 2.
